board_line_clear: RTL

- Playfield datapath for the Tetris control FSM.
- Holds the ROWS x COLS occupancy board and merges the landed piece on update_board_state.
- Produces the per-row completed_lines vector that the FSM tests in its check-lines state.
- Removes one completed row per shift_down pulse, and keeps line and score counters for the display path.

---
 rtl/board_line_clear_if.sv | 43 ++++
 rtl/board_line_clear.sv | 130 +++++++++++++
 2 files changed

// File: rtl/board_line_clear_if.sv
// Command/status bundle for the board_line_clear playfield datapath.
// Optional macro BOARD_LEVEL_MULT_EN adds the 4-bit level status signal.
// Handshake: clear_board, update_board_state and shift_down are single-cycle
// command pulses sampled on every rising clock edge; there is no ready, the
// datapath accepts at most one command per cycle (clear > update > shift) and
// all status outputs are always valid.
interface board_line_clear_if #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int LINES_W = 16,
    parameter int SCORE_W = 20
);
    logic                   clear_board;
    logic                   update_board_state;
    logic [ROWS*COLS-1:0]   piece_mask;
    logic                   shift_down;
    logic [ROWS*COLS-1:0]   board;
    logic [ROWS-1:0]        completed_lines;
    logic [LINES_W-1:0]     lines_cleared;
    logic [SCORE_W-1:0]     score;
    logic                   collision;
`ifdef BOARD_LEVEL_MULT_EN
    logic [3:0]             level;

    modport master (
        output clear_board, update_board_state, piece_mask, shift_down,
        input  board, completed_lines, lines_cleared, score, collision, level
    );
    modport slave (
        input  clear_board, update_board_state, piece_mask, shift_down,
        output board, completed_lines, lines_cleared, score, collision, level
    );
`else
    modport master (
        output clear_board, update_board_state, piece_mask, shift_down,
        input  board, completed_lines, lines_cleared, score, collision
    );
    modport slave (
        input  clear_board, update_board_state, piece_mask, shift_down,
        output board, completed_lines, lines_cleared, score, collision
    );
`endif
endinterface

// File: rtl/board_line_clear.sv
// Tetris playfield datapath: occupancy board, piece merge, completed-row
// detection, one-row-per-pulse line removal, line and score counters.
// Optional macro BOARD_LEVEL_MULT_EN scales each score increment by
// (level+1), level = min(lines_cleared/10, 15), and exports level.
module board_line_clear #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int LINES_W = 16,
    parameter int SCORE_W = 20
) (
    input  logic clock,
    input  logic resetn,
    board_line_clear_if.slave bus
);
    localparam int CELLS = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    // Wide enough that score + (900 * 16) can never overflow before clamping.
    localparam int SUM_W = SCORE_W + 16;

    logic [CELLS-1:0]   board_q;
    logic [CELLS-1:0]   board_down;
    logic [CELLS-1:0]   board_shifted;
    logic [ROWS-1:0]    full_rows;
    logic [ROW_W-1:0]   sel_row;
    logic [LINES_W-1:0] lines_q;
    logic [SCORE_W-1:0] score_q;
    logic               collision_q;
    logic [2:0]         combo_q;
    logic [2:0]         combo_inc;
    logic [SUM_W-1:0]   base_inc;
    logic [SUM_W-1:0]   add_val;
    logic [SUM_W-1:0]   sum_wide;
    logic [SCORE_W-1:0] score_sat;

    // A row is complete when all of its columns are occupied.
    always_comb begin
        full_rows = '0;
        for (int r = 0; r < ROWS; r++) begin
            full_rows[r] = &board_q[r*COLS +: COLS];
        end
    end

    // Pick the highest-index (lowest on screen) completed row.
    always_comb begin
        sel_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (full_rows[r]) sel_row = ROW_W'(r);
        end
    end

    // Whole board moved down one row; row 0 becomes empty.
    assign board_down = board_q << COLS;

    // Rows at or above the removed row take the row above; rows below keep.
    always_comb begin
        board_shifted = board_q;
        for (int k = 0; k < ROWS; k++) begin
            if (k <= int'(sel_row)) begin
                board_shifted[k*COLS +: COLS] = board_down[k*COLS +: COLS];
            end
        end
    end

    // Per-piece combo count and its incremental score value.
    always_comb begin
        combo_inc = (combo_q >= 3'd4) ? 3'd4 : combo_q + 3'd1;
        case (combo_inc)
            3'd1:    base_inc = SUM_W'(40);
            3'd2:    base_inc = SUM_W'(60);
            3'd3:    base_inc = SUM_W'(200);
            default: base_inc = SUM_W'(900);
        endcase
    end

`ifdef BOARD_LEVEL_MULT_EN
    logic [LINES_W-1:0] lines_div;
    logic [3:0]         level;

    // Level from the line count before this clear, capped at 15.
    always_comb begin
        lines_div = lines_q / LINES_W'(10);
        level     = (lines_div > LINES_W'(15)) ? 4'd15 : lines_div[3:0];
        add_val   = base_inc * (SUM_W'(level) + SUM_W'(1));
    end

    assign bus.level = level;
`else
    assign add_val = base_inc;
`endif

    // Saturating score addition; the score never wraps.
    always_comb begin
        sum_wide  = SUM_W'(score_q) + add_val;
        score_sat = (sum_wide > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                          : sum_wide[SCORE_W-1:0];
    end

    // Board and counters; clear beats update beats shift within one cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            board_q     <= '0;
            lines_q     <= '0;
            score_q     <= '0;
            collision_q <= 1'b0;
            combo_q     <= '0;
        end else if (bus.clear_board) begin
            board_q     <= '0;
            lines_q     <= '0;
            score_q     <= '0;
            collision_q <= 1'b0;
            combo_q     <= '0;
        end else if (bus.update_board_state) begin
            board_q <= board_q | bus.piece_mask;
            combo_q <= '0;
            if ((board_q & bus.piece_mask) != '0) collision_q <= 1'b1;
        end else if (bus.shift_down && (full_rows != '0)) begin
            board_q <= board_shifted;
            combo_q <= combo_inc;
            score_q <= score_sat;
            if (lines_q != {LINES_W{1'b1}}) lines_q <= lines_q + LINES_W'(1);
        end
    end

    assign bus.board           = board_q;
    assign bus.completed_lines = full_rows;
    assign bus.lines_cleared   = lines_q;
    assign bus.score           = score_q;
    assign bus.collision       = collision_q;

endmodule
